// File: rtl/tile_blitter_if.sv
// tile_blitter_if: datapath/ROM/VGA-side signal bundle for tile_blitter.
// Ports (slave = blitter side):
//   in : go, X, Y, memory_select, tile_select, rom_data
//   out: rom_addr, rom_sel, X_out, Y_out, colour, write_en, busy, finished
interface tile_blitter_if;
   logic        go;
   logic [8:0]  X;
   logic [7:0]  Y;
   logic [1:0]  memory_select;
   logic [3:0]  tile_select;
   logic [16:0] rom_addr;
   logic [1:0]  rom_sel;
   logic [2:0]  rom_data;
   logic [8:0]  X_out;
   logic [7:0]  Y_out;
   logic [2:0]  colour;
   logic        write_en;
   logic        busy;
   logic        finished;
   modport slave (
      input  go, X, Y, memory_select, tile_select, rom_data,
      output rom_addr, rom_sel, X_out, Y_out, colour, write_en, busy, finished
   );
   modport master (
      output go, X, Y, memory_select, tile_select, rom_data,
      input  rom_addr, rom_sel, X_out, Y_out, colour, write_en, busy, finished
   );
endinterface

// File: rtl/tile_blitter.sv
// tile_blitter: streams a tile or the full stage image from ROM to the VGA write port, one pixel per clock.
// Ports: clock, reset_n (async active-low); bus (tile_blitter_if.slave) carries go/origin/select in,
//   ROM address/select out with ROM colour in, and VGA X_out/Y_out/colour/write_en plus busy/finished out.
// Option: define TILE_BLITTER_TRANSPARENCY_EN to drop magenta (3'b101) tile pixels.
module tile_blitter #(
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int TILE_W   = 16
) (
   input logic           clock,
   input logic           reset_n,
   tile_blitter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SWEEP, FLUSH, DONE} state_t;
   state_t      state_q, state_d;
   logic [8:0]  x_q, x_d, px_q, px_d;
   logic [7:0]  y_q, y_d, py_q, py_d;
   logic [3:0]  tile_q, tile_d;
   logic [1:0]  sel_q, sel_d;
   logic [9:0]  col_q, col_d, col;
   logic [8:0]  row_q, row_d, row;
   logic        vld_q, vld_d;
   logic        stage, px_last, py_last;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         px_q    <= '0;
         py_q    <= '0;
         tile_q  <= '0;
         sel_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         px_q    <= px_d;
         py_q    <= py_d;
         tile_q  <= tile_d;
         sel_q   <= sel_d;
         col_q   <= col_d;
         row_q   <= row_d;
         vld_q   <= vld_d;
      end
   end

   always_comb begin
      stage   = sel_q == 2'd1;
      px_last = px_q == (stage ? 9'(SCREEN_W - 1) : 9'(TILE_W - 1));
      py_last = py_q == (stage ? 8'(SCREEN_H - 1) : 8'(TILE_W - 1));
      col     = 10'(x_q) + 10'(px_q);
      row     = 9'(y_q) + 9'(py_q);
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      px_d    = px_q;
      py_d    = py_q;
      tile_d  = tile_q;
      sel_d   = sel_q;
      col_d   = col_q;
      row_d   = row_q;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: if (bus.go) begin
            state_d = SWEEP;
            sel_d   = (bus.memory_select == 2'd1) ? 2'd1 : 2'd0;
            x_d     = (bus.memory_select == 2'd1) ? 9'd0 : bus.X;
            y_d     = (bus.memory_select == 2'd1) ? 8'd0 : bus.Y;
            tile_d  = bus.tile_select;
            px_d    = '0;
            py_d    = '0;
         end
         SWEEP: begin
            // Coordinates travel one stage behind the address to line up with rom_data.
            col_d = col;
            row_d = row;
            vld_d = (col < 10'(SCREEN_W)) && (row < 9'(SCREEN_H));
            px_d  = px_last ? 9'd0 : px_q + 9'd1;
            py_d  = (px_last && !py_last) ? py_q + 8'd1 : py_q;
            if (px_last && py_last) state_d = FLUSH;
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.rom_addr = stage ? 17'(py_q) * 17'(SCREEN_W) + 17'(px_q)
                               : 17'({tile_q, py_q[3:0], px_q[3:0]});
   assign bus.rom_sel  = sel_q;
   assign bus.X_out    = col_q[8:0];
   assign bus.Y_out    = row_q[7:0];
   assign bus.colour   = vld_q ? bus.rom_data : 3'd0;
`ifdef TILE_BLITTER_TRANSPARENCY_EN
   assign bus.write_en = vld_q && !(sel_q == 2'd0 && bus.rom_data == 3'b101);
`else
   assign bus.write_en = vld_q;
`endif
   assign bus.busy     = state_q != IDLE;
   assign bus.finished = state_q == DONE;
endmodule
